// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D-cache memory-port arbiter.
package mem_arb_pkg;

    localparam int MEM_ARB_ADDR_W = 28;
    localparam int MEM_ARB_DATA_W = 128;

    // Requester IDs used for the pick result and last_gnt.
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side and memory-side line-transfer signals around mem_arbiter.
// slave: arbiter view. master: view of the environment (caches plus memory).
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::MEM_ARB_ADDR_W,
    parameter int DATA_W = mem_arb_pkg::MEM_ARB_DATA_W
);
    logic              mem_read_I;
    logic              mem_write_I;
    logic [ADDR_W-1:0] mem_addr_I;
    logic [DATA_W-1:0] mem_wdata_I;
    logic [DATA_W-1:0] mem_rdata_I;
    logic              mem_ready_I;

    logic              mem_read_D;
    logic              mem_write_D;
    logic [ADDR_W-1:0] mem_addr_D;
    logic [DATA_W-1:0] mem_wdata_D;
    logic [DATA_W-1:0] mem_rdata_D;
    logic              mem_ready_D;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  mem_read_I, mem_write_I, mem_addr_I, mem_wdata_I,
        output mem_rdata_I, mem_ready_I,
        input  mem_read_D, mem_write_D, mem_addr_D, mem_wdata_D,
        output mem_rdata_D, mem_ready_D,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output mem_read_I, mem_write_I, mem_addr_I, mem_wdata_I,
        input  mem_rdata_I, mem_ready_I,
        output mem_read_D, mem_write_D, mem_addr_D, mem_wdata_D,
        input  mem_rdata_D, mem_ready_D,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select for an IDLE arbitration cycle.
// MEM_ARB_ROUND_ROBIN_EN: defined -> alternate on contention using last_gnt;
// undefined -> fixed priority, D over I.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_gnt,
    output logic pick
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On contention the requester that did not complete last goes next.
    always_comb begin
        pick = REQ_I;
        if (req_i && req_d) begin
            pick = ~last_gnt;
        end else if (req_d) begin
            pick = REQ_D;
        end
    end
`else
    // D wins whenever it asks; I only when D is quiet.
    logic [1:0] unused_pick_inputs;
    assign unused_pick_inputs = {req_i, last_gnt};

    always_comb begin
        pick = REQ_I;
        if (req_d) begin
            pick = REQ_D;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between I-cache and D-cache. The grant is
// held for one full transaction (request to mem_ready, or requester abort)
// and always passes through IDLE before re-arbitrating.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; default is D-first.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ARB_ADDR_W,
    parameter int DATA_W = MEM_ARB_DATA_W
) (
    input  logic          clk,
    input  logic          proc_reset,
    mem_arbiter_if.slave  bus
);

    state_t            state;
    state_t            state_next;
    logic              req_i;
    logic              req_d;
    logic              pick;
    logic              last_gnt;

    logic              read_sel;
    logic              write_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic [DATA_W-1:0] rdata_i;
    logic [DATA_W-1:0] rdata_d;
    logic              ready_i;
    logic              ready_d;

    assign req_i = bus.mem_read_I | bus.mem_write_I;
    assign req_d = bus.mem_read_D | bus.mem_write_D;

    mem_arb_pick u_pick (
        .req_i    (req_i),
        .req_d    (req_d),
        .last_gnt (last_gnt),
        .pick     (pick)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remember who completed last; aborts leave it unchanged.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            last_gnt <= REQ_I;
        end else if (bus.mem_ready) begin
            if (state == GNT_I) begin
                last_gnt <= REQ_I;
            end else if (state == GNT_D) begin
                last_gnt <= REQ_D;
            end
        end
    end
`else
    assign last_gnt = REQ_I;
`endif

    // Grant state register.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next grant plus owner-selected command and return-path muxing.
    always_comb begin
        state_next = state;
        read_sel   = 1'b0;
        write_sel  = 1'b0;
        addr_sel   = '0;
        wdata_sel  = '0;
        rdata_i    = '0;
        rdata_d    = '0;
        ready_i    = 1'b0;
        ready_d    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_i || req_d) begin
                    state_next = (pick == REQ_D) ? GNT_D : GNT_I;
                end
            end
            GNT_I: begin
                read_sel  = bus.mem_read_I;
                write_sel = bus.mem_write_I;
                addr_sel  = bus.mem_addr_I;
                wdata_sel = bus.mem_wdata_I;
                rdata_i   = bus.mem_rdata;
                ready_i   = bus.mem_ready;
                if (bus.mem_ready || !req_i) begin
                    state_next = IDLE;
                end
            end
            GNT_D: begin
                read_sel  = bus.mem_read_D;
                write_sel = bus.mem_write_D;
                addr_sel  = bus.mem_addr_D;
                wdata_sel = bus.mem_wdata_D;
                rdata_d   = bus.mem_rdata;
                ready_d   = bus.mem_ready;
                if (bus.mem_ready || !req_d) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.mem_read    = read_sel;
    assign bus.mem_write   = write_sel;
    assign bus.mem_addr    = addr_sel;
    assign bus.mem_wdata   = wdata_sel;
    assign bus.mem_rdata_I = rdata_i;
    assign bus.mem_rdata_D = rdata_d;
    assign bus.mem_ready_I = ready_i;
    assign bus.mem_ready_D = ready_d;

endmodule
